// File: rtl/camera_frame_emulator.sv
// Image-sensor parallel-port transmitter: Strobe, FV, LV and 12-bit pixels.
// Optional CAM_EMU_LFSR_EN: pattern 3 becomes a 12-bit LFSR instead of 12'hA5A.
module camera_frame_emulator #(
    parameter int H_ACTIVE   = 16,
    parameter int V_ACTIVE   = 8,
    parameter int H_BLANK    = 4,
    parameter int V_PRE      = 2,
    parameter int V_POST     = 2,
    parameter int STROBE_LEN = 3
) (
    input  logic        sysClk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic [1:0]  pattern_sel,
    output logic [11:0] pixel_data_out,
    output logic        FV,
    output logic        LV,
    output logic        Strobe,
    output logic        busy,
    output logic        frame_done,
    output logic        trig_overrun
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int M1 = (STROBE_LEN > H_BLANK) ? STROBE_LEN : H_BLANK;
    localparam int M2 = (V_PRE > V_POST) ? V_PRE : V_POST;
    localparam int CM = (M1 > M2) ? M1 : M2;
    localparam int CW = (CM > 1) ? $clog2(CM) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] C_STB  = CW'(STROBE_LEN - 1);
    localparam logic [CW-1:0] C_PRE  = CW'(V_PRE - 1);
    localparam logic [CW-1:0] C_HBL  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] C_PST  = CW'(V_POST - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_STROBE, S_PRE, S_ACTIVE,
        S_HBLANK, S_POST, S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [11:0]     n;
    logic [1:0]      pat;
    logic            accept;
    logic            fv_d;
    logic            lv_d;
    logic            strobe_d;
    logic            busy_d;
    logic            done_d;
    logic [11:0]     pix_d;
`ifdef CAM_EMU_LFSR_EN
    logic [11:0]     lfsr;
`endif

    // busy is the registered output, so the frame_done cycle still blocks
    assign accept = (state == S_IDLE) && trigger && !busy;

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (accept) next_state = S_STROBE;
            S_STROBE: if (cnt == C_STB) next_state = S_PRE;
            S_PRE:    if (cnt == C_PRE) next_state = S_ACTIVE;
            S_ACTIVE: if (x == X_LAST)
                          next_state = (y == Y_LAST) ? S_POST : S_HBLANK;
            S_HBLANK: if (cnt == C_HBL) next_state = S_ACTIVE;
            S_POST:   if (cnt == C_PST) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        fv_d     = (state == S_PRE) || (state == S_ACTIVE) ||
                   (state == S_HBLANK) || (state == S_POST);
        lv_d     = (state == S_ACTIVE);
        strobe_d = (state == S_STROBE);
        busy_d   = accept || (state != S_IDLE);
        done_d   = (state == S_DONE);
        pix_d    = 12'h000;
        if (state == S_ACTIVE) begin
            unique case (pat)
                2'd0: pix_d = n;
                2'd1: pix_d = 12'(x);
                2'd2: pix_d = 12'(y);
`ifdef CAM_EMU_LFSR_EN
                2'd3: pix_d = lfsr;
`else
                2'd3: pix_d = 12'hA5A;
`endif
                default: pix_d = 12'h000;
            endcase
        end
    end

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            x              <= '0;
            y              <= '0;
            n              <= '0;
            pat            <= '0;
            pixel_data_out <= '0;
            FV             <= 1'b0;
            LV             <= 1'b0;
            Strobe         <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            trig_overrun   <= 1'b0;
        end else begin
            if (state == S_IDLE || state != next_state) cnt <= '0;
            else                                        cnt <= cnt + CW'(1);
            if (state == S_ACTIVE) begin
                x <= (x == X_LAST) ? '0 : x + XW'(1);
                n <= n + 12'd1;
                if (x == X_LAST) y <= y + YW'(1);
            end else if (state == S_IDLE) begin
                x <= '0;
                y <= '0;
                n <= '0;
            end
            if (accept) pat <= pattern_sel;
            pixel_data_out <= pix_d;
            FV             <= fv_d;
            LV             <= lv_d;
            Strobe         <= strobe_d;
            busy           <= busy_d;
            frame_done     <= done_d;
            trig_overrun   <= trig_overrun | (trigger & busy);
        end
    end

`ifdef CAM_EMU_LFSR_EN
    // Fibonacci taps for x^12+x^6+x^4+x+1, reseeded every frame
    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n)                 lfsr <= 12'h001;
        else if (state == S_IDLE)   lfsr <= 12'h001;
        else if (state == S_ACTIVE)
            lfsr <= {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
    end
`endif

endmodule

// File: doc/camera_frame_emulator.md
# camera_frame_emulator

Transmit-side model of the image-sensor parallel port: on a trigger it emits one frame as Strobe, FV, LV and 12-bit pixel data, timed like the sensor output that feeds the camera input grabber. It sits in front of the grabber, in place of the physical camera, for loopback bring-up and self-test on the FPGA. It also serves as the stimulus source in grabber benches. Frame geometry is set by parameters, and the pixel content comes from a selectable deterministic pattern.

## Interface
- H_ACTIVE, 16: pixels per line (LV high cycles), ≥1
- V_ACTIVE, 8: lines per frame, ≥1
- H_BLANK, 4: LV-low cycles between lines, ≥1
- V_PRE, 2: FV-high, LV-low cycles before the first line, ≥1
- V_POST, 2: FV-high, LV-low cycles after the last line, ≥1
- STROBE_LEN, 3: Strobe-high cycles before FV rises, ≥1

Ports:
- sysClk  in  1  system clock, all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- trigger  in  1  single-cycle frame request, same semantics as trigger2_event_flag
- pattern_sel  in  2  0 = incrementing, 1 = column ramp, 2 = row ramp, 3 = constant 12'hA5A
- pixel_data_out  out  12  pixel value, 0 whenever LV=0
- FV  out  1  frame valid
- LV  out  1  line valid, only ever high while FV=1
- Strobe  out  1  exposure strobe
- busy  out  1  high from trigger acceptance through the frame_done cycle
- frame_done  out  1  one-cycle pulse after FV falls
- trig_overrun  out  1  sticky flag: a trigger arrived while busy. Cleared only by reset.

## Operation
- All outputs are registered. All outputs reset to 0 asynchronously on rst_n low. Operation starts on the first edge after rst_n deasserts.
- State machine: IDLE → STROBE → PRE → ACTIVE ⇄ HBLANK → POST → DONE → IDLE.
- IDLE: trigger=1 at an edge moves the state to STROBE and sets busy. pattern_sel is latched at this edge and held for the whole frame.
- STROBE: Strobe=1 for STROBE_LEN cycles.
- PRE: FV=1 for V_PRE cycles.
- ACTIVE: FV=LV=1 for H_ACTIVE cycles, one pixel per cycle.
- HBLANK: FV=1, LV=0 for H_BLANK cycles. Entered only between lines; after the last line the FSM goes directly to POST.
- POST: FV=1 for V_POST cycles.
- DONE: FV=0, frame_done=1, busy=1 for one cycle, then IDLE with busy=0.
- Counters: column x is 0..H_ACTIVE-1, row y is 0..V_ACTIVE-1, linear index n = y·H_ACTIVE + x.
- Each counter is sized with $clog2 of its parameter.
- Pattern values:
  - 0: n[11:0], wrapping modulo 4096, restarting at 0 each frame.
  - 1: x[11:0].
  - 2: y[11:0].
  - 3: 12'hA5A.
- A trigger while busy (including in the DONE cycle) is ignored and sets trig_overrun. A trigger in IDLE together with the DONE→IDLE edge cannot occur, since DONE holds busy.
- Reset mid-frame: all outputs drop to 0 immediately (asynchronous), the FSM returns to IDLE, and the latched pattern and counters clear.

## Timing
- Trigger accepted at edge k:
  - Strobe is high from k+1 through k+STROBE_LEN.
  - FV rises at edge k+STROBE_LEN+1.
  - The first LV rises V_PRE cycles after FV.
- Frame FV-high length = V_PRE + V_ACTIVE·H_ACTIVE + (V_ACTIVE−1)·H_BLANK + V_POST cycles. With the default parameters this is 2+128+28+2 = 160.
- frame_done is high in the first cycle with FV=0.
- The earliest next trigger accepted is the edge after frame_done.
- Pixel data is valid in exactly the cycles where FV&LV. No pipeline skew between LV and the data.
- The grabber adds its own 3-stage input delay; this block adds none.

## Configuration
- CAM_EMU_LFSR_EN defined: pattern_sel=3 outputs a 12-bit Fibonacci LFSR instead of the constant.
  - Polynomial x^12+x^6+x^4+x+1.
  - Seed 12'h001 at frame start.
  - Advances once per cycle with LV=1.
  - The first pixel of a frame is 12'h001.
- CAM_EMU_LFSR_EN undefined: pattern 3 is the constant 12'hA5A, and no LFSR logic is synthesized.

## Test plan
- Reset/idle: rst_n low → all outputs 0. Release with no trigger for 50 cycles → FV=LV=Strobe=busy=0.
- Default frame, pattern 0, trigger at edge k:
  - Strobe high for exactly 3 cycles.
  - FV high for 160 cycles starting at k+4.
  - 8 LV bursts of 16 cycles, separated by 4 low cycles.
  - Data runs 0..127 in order.
  - frame_done pulses once.
- Patterns 1/2/3: check per-line data 0..15 (pattern 1). Check line y data constant at y (pattern 2). Check all pixels 12'hA5A, or the LFSR sequence from 12'h001 with the macro defined (pattern 3).
- Overrun and latch: retrigger mid-frame → frame unchanged and trig_overrun=1. pattern_sel changed mid-frame → no effect until the next frame.
- Reset mid-frame (rst_n low during the 3rd LV burst): outputs go to 0 asynchronously. A new trigger then yields a complete, correct frame.
- Wrap: H_ACTIVE=128, V_ACTIVE=40, pattern 0 → pixel 4096 reads 0, and the last pixel reads 5119 mod 4096 = 1023.
